seq_detect_mc: RTL and testbench
================================

SEQ_DETECT_MC -- requirements
Module: seq_detect_mc

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning maximum pattern length in bits (2..32).
REQ-002 The block SHALL have parameter CH, default 4, meaning number of independent serial input channels (1..16).
REQ-003 The block SHALL have parameter CNTW, default 8, meaning per-channel match counter width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 a  input  CH  serial data bit per channel; a[c] belongs to channel c.
REQ-007 in_en  input  1  bit strobe; a is sampled only on cycles with in_en=1.
REQ-008 seq  input  N  pattern; seq[0] is the first bit of the pattern in arrival order.
REQ-009 len  input  $clog2(N+1)  active pattern length.
REQ-010 overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-011 load  input  1  latches seq, len and overlap into configuration registers.
REQ-012 clr_cnt  input  1  clears all match counters.
REQ-013 valid  output  CH  registered one-cycle match pulse per channel.
REQ-014 count  output  CH*CNTW  match counters; channel c occupies bits [c*CNTW +: CNTW].

Function
REQ-015 Detection SHALL use only the configuration registers (cfg_seq, cfg_len, cfg_ovl), never the live seq/len/overlap inputs.
REQ-016 On load=1, cfg registers SHALL update at that clock edge; loaded len=0 SHALL be stored as 1, len>N stored as N.
REQ-017 A load SHALL clear every channel's history and fill count in the same edge; a bit with in_en=1 in the load cycle SHALL be discarded.
REQ-018 Each channel SHALL keep an N-bit history h (h[0] = most recent accepted bit) and a fill counter saturating at N.
REQ-019 On in_en=1 (and no load), each channel SHALL shift a[c] into h[0] and increment fill (saturating).
REQ-020 A channel match SHALL occur when, after the shift, fill >= cfg_len and h[k] == cfg_seq[cfg_len-1-k] for all k < cfg_len.
REQ-021 valid[c] SHALL be 1 for exactly the cycle following the in_en edge that produced the match, else 0; latency = 1 clock.
REQ-022 With cfg_ovl=1, history and fill SHALL be retained after a match.
REQ-023 With cfg_ovl=0, fill SHALL be set to 0 on the match edge, so the next match needs cfg_len fresh bits.
REQ-024 in_en=0 SHALL leave history, fill and counters unchanged and force valid to 0 next cycle.
REQ-025 count[c] SHALL increment by 1 per match and saturate at 2^CNTW-1 (no wrap).
REQ-026 clr_cnt=1 SHALL set all counters to 0, taking priority over a simultaneous match; valid still pulses for that match.
REQ-027 Channels SHALL be fully independent; simultaneous matches on several channels SHALL each pulse and count.

Reset
REQ-028 reset=1 SHALL, at the clock edge, set valid=0, all counts=0, all histories=0, all fills=0, cfg_seq=0, cfg_len=N, cfg_ovl=0.
REQ-029 reset SHALL take priority over load, clr_cnt and in_en; reset mid-pattern SHALL discard partial history.

Verification (N=8, CH=4, CNTW=8 unless stated)
REQ-030 load seq=8'b110, len=3, overlap=1; ch0 stream 0,1,1,0,1,1 -> valid[0] pulses after bits 3 and 6, count[0]=2, other channels 0.
REQ-031 load seq=8'b111, len=3; six consecutive 1s on ch1 -> overlap=1: 4 pulses, count=4; overlap=0: 2 pulses (bits 3, 6), count=2.
REQ-032 seq=8'b110, len=3; ch2 bits 0,1 then reset for 1 cycle, then bit 1 -> no valid pulse, count[2]=0.
REQ-033 CNTW=2, seq=1'b1, len=1, overlap=1; five 1s with in_en gaps -> 5 valid pulses, count=3, valid=0 during gaps.
REQ-034 clr_cnt asserted on the edge of a match with count=5 -> count=0 next cycle, valid pulses once; load with len=0 then single 1 on seq[0]=1 -> match (len treated as 1).
REQ-035 Identical stream 0,1,1 on all four channels with seq=8'b110, len=3 -> valid=4'b1111 for one cycle, all counts=1.

Source files
------------

// File: rtl/seq_detect_mc.sv
// Multi-channel serial pattern detector: CH independent bit streams are matched against one
// shared, load-latched pattern of 1..N bits. Each channel has a registered match pulse and a
// saturating match counter.
// Latency: valid[c] rises one clock after the strobed bit that completes the pattern.
// Backpressure: none. Bits are taken on every cycle with in_en=1, and the block never stalls.
//
// Ports:
//   clk, reset  : single clock; synchronous active-high reset
//   a[CH]       : one serial data bit per channel, sampled only when in_en=1
//   in_en       : bit strobe
//   seq/len/overlap, load : pattern, its length and overlap mode, latched on load
//   clr_cnt     : clears all match counters
//   valid[CH]   : one-cycle match pulse per channel
//   count       : packed per-channel match counters; channel c is [c*CNTW +: CNTW]
module seq_detect_mc #(
  parameter int N    = 8,
  parameter int CH   = 4,
  parameter int CNTW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CH-1:0]           a,
  input  logic                    in_en,
  input  logic [N-1:0]            seq,
  input  logic [$clog2(N+1)-1:0]  len,
  input  logic                    overlap,
  input  logic                    load,
  input  logic                    clr_cnt,
  output logic [CH-1:0]           valid,
  output logic [CH*CNTW-1:0]      count
);

  localparam int               LW   = $clog2(N+1);
  localparam logic [LW-1:0]    NL   = LW'(N);
  localparam logic [CNTW-1:0]  CMAX = '1;

  logic [N-1:0]    cfg_seq;
  logic [LW-1:0]   cfg_len;
  logic            cfg_ovl;

  logic [N-1:0]    hist [CH];
  logic [LW-1:0]   fill [CH];
  logic [CNTW-1:0] cnt  [CH];

  logic [N-1:0]    sh_hist [CH];
  logic [LW-1:0]   sh_fill [CH];
  logic [CH-1:0]   hit;

  logic [N-1:0]    rev_seq;
  logic [N-1:0]    exp_hist;
  logic [N-1:0]    len_mask;
  logic [LW-1:0]   len_in;

  // Clamp the requested length into 1..N before it is latched.
  always_comb begin
    len_in = len;
    if (len == '0) len_in = LW'(1);
    else if (len > NL) len_in = NL;
  end

  // The history holds the newest bit in h[0], so h[k] must equal cfg_seq[len-1-k].
  // Bit-reversing the whole pattern and then shifting right by (N-len) lines the
  // pattern up with the history without any variable part-select.
  always_comb begin
    for (int i = 0; i < N; i++) rev_seq[i] = cfg_seq[N-1-i];
    exp_hist = rev_seq >> (NL - cfg_len);
    len_mask = ~({N{1'b1}} << cfg_len);
  end

  // Next history and fill for an accepted bit, and the match test on that post-shift state.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sh_hist[c] = {hist[c][N-2:0], a[c]};
      sh_fill[c] = (fill[c] == NL) ? fill[c] : fill[c] + LW'(1);
      hit[c]     = (sh_fill[c] >= cfg_len) &&
                   (((sh_hist[c] ^ exp_hist) & len_mask) == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_seq <= '0;
      cfg_len <= NL;
      cfg_ovl <= 1'b0;
      valid   <= '0;
      for (int c = 0; c < CH; c++) begin
        hist[c] <= '0;
        fill[c] <= '0;
        cnt[c]  <= '0;
      end
    end else begin
      // The pulse comes only from a bit that was actually accepted. A load cycle drops its bit.
      valid <= (in_en && !load) ? hit : '0;

      if (load) begin
        cfg_seq <= seq;
        cfg_len <= len_in;
        cfg_ovl <= overlap;
      end

      for (int c = 0; c < CH; c++) begin
        if (load) begin
          hist[c] <= '0;
          fill[c] <= '0;
        end else if (in_en) begin
          hist[c] <= sh_hist[c];
          // In non-overlapping mode, a match consumes the bits that formed it.
          fill[c] <= (hit[c] && !cfg_ovl) ? '0 : sh_fill[c];
        end

        // Clearing the counters wins over a match on the same edge.
        if (clr_cnt) begin
          cnt[c] <= '0;
        end else if (in_en && !load && hit[c] && (cnt[c] != CMAX)) begin
          cnt[c] <= cnt[c] + CNTW'(1);
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int c = 0; c < CH; c++) count[c*CNTW +: CNTW] = cnt[c];
  end

endmodule

// File: tb/tb_seq_detect_mc.sv
module tb_seq_detect_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  a;
  logic        in_en;
  logic [7:0]  seq;
  logic [3:0]  len;
  logic        overlap;
  logic        load;
  logic        clr_cnt;
  logic [3:0]  valid;
  logic [31:0] count;
  logic [3:0]  valid2;
  logic [7:0]  count2;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  seq_detect_mc #(.N(8), .CH(4), .CNTW(8)) u_dut (
    .clk(clk), .reset(reset), .a(a), .in_en(in_en), .seq(seq), .len(len),
    .overlap(overlap), .load(load), .clr_cnt(clr_cnt), .valid(valid), .count(count)
  );

  // This instance gets identical stimulus, but its counters are only 2 bits wide, so they saturate at 3.
  seq_detect_mc #(.N(8), .CH(4), .CNTW(2)) u_dut2 (
    .clk(clk), .reset(reset), .a(a), .in_en(in_en), .seq(seq), .len(len),
    .overlap(overlap), .load(load), .clr_cnt(clr_cnt), .valid(valid2), .count(count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (step %0d): observed %h expected %h", tag, step_no, obs, exp);
    end
  endtask

  // One clock of stimulus. The expected valid is queued when the stimulus is driven and
  // compared after the edge that produces the response.
  task automatic step(input logic [3:0] av, input logic en, input logic ld,
                      input logic clr, input logic rst, input logic [3:0] expv);
    logic [3:0] e;
    a = av; in_en = en; load = ld; clr_cnt = clr; reset = rst;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    step_no++;
    a = '0; in_en = 1'b0; load = 1'b0; clr_cnt = 1'b0; reset = 1'b0;
    e = exp_q.pop_front();
    chk("valid", 32'(valid), 32'(e));
    chk("valid_cntw2", 32'(valid2), 32'(e));
  endtask

  // Load a configuration while a strobed bit is present. That bit must be discarded.
  task automatic ld_cfg(input logic [7:0] s, input logic [3:0] l, input logic o);
    seq = s; len = l; overlap = o;
    step(4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic clr;
    step(4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("count_after_clr", count, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    seq = '0; len = '0; overlap = 1'b0; a = '0; in_en = 1'b0;
    load = 1'b0; clr_cnt = 1'b0; reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset wins over a simultaneous load, clr_cnt and strobed bit.
    seq = 8'hFF; len = 4'd1; overlap = 1'b1;
    step(4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
    chk("reset_count", count, 32'h0);
    chk("reset_count_cntw2", 32'(count2), 32'h0);
    // The reset configuration is pattern 0 with length 8, so eight zeros match on every channel.
    for (int i = 0; i < 7; i++) step(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
    chk("reset_cfg_count", count, 32'h01010101);
    clr();

    // Pattern 0,1,1 with overlap on ch0. Matches occur after bits 3 and 6.
    ld_cfg(8'b110, 4'd3, 1'b1);
    step(4'h0, 1, 0, 0, 0, 4'h0);
    step(4'h1, 1, 0, 0, 0, 4'h0);
    step(4'h1, 1, 0, 0, 0, 4'h1);
    step(4'h0, 1, 0, 0, 0, 4'h0);
    step(4'h1, 1, 0, 0, 0, 4'h0);
    step(4'h1, 1, 0, 0, 0, 4'h1);
    chk("p011_count", count, 32'h00000002);
    chk("p011_count_cntw2", 32'(count2), 32'h2);
    clr();

    // Six ones on ch1 with pattern 111. Overlap gives 4 matches, non-overlap gives 2.
    ld_cfg(8'b111, 4'd3, 1'b1);
    step(4'h2, 1, 0, 0, 0, 4'h0);
    step(4'h2, 1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) step(4'h2, 1, 0, 0, 0, 4'h2);
    chk("ovl1_count", count, 32'h00000400);
    clr();
    ld_cfg(8'b111, 4'd3, 1'b0);
    step(4'h2, 1, 0, 0, 0, 4'h0);
    step(4'h2, 1, 0, 0, 0, 4'h0);
    step(4'h2, 1, 0, 0, 0, 4'h2);
    step(4'h2, 1, 0, 0, 0, 4'h0);
    step(4'h2, 1, 0, 0, 0, 4'h0);
    step(4'h2, 1, 0, 0, 0, 4'h2);
    chk("ovl0_count", count, 32'h00000200);
    clr();

    // A reset in the middle of a pattern discards the partial history on ch2.
    ld_cfg(8'b110, 4'd3, 1'b1);
    step(4'h0, 1, 0, 0, 0, 4'h0);
    step(4'h4, 1, 0, 0, 0, 4'h0);
    step(4'h0, 0, 0, 0, 1, 4'h0);
    step(4'h4, 1, 0, 0, 0, 4'h0);
    chk("midreset_count", count, 32'h0);

    // Single-bit pattern with gaps in in_en. The 2-bit counter saturates at 3.
    ld_cfg(8'h01, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'h1, 1, 0, 0, 0, 4'h1);
      step(4'h1, 0, 0, 0, 0, 4'h0);
    end
    chk("gap_count", count, 32'h00000005);
    chk("sat_count_cntw2", 32'(count2), 32'h3);

    // Clearing on the edge of a match: the counter reads 0 and valid still pulses.
    step(4'h1, 1, 0, 1, 0, 4'h1);
    chk("clr_on_match_count", count, 32'h0);
    step(4'h1, 1, 0, 0, 0, 4'h1);
    chk("count_after_clr_match", count, 32'h1);

    // Loading len=0 behaves as len=1: a 1 matches and a 0 does not.
    ld_cfg(8'h01, 4'd0, 1'b1);
    step(4'h8, 1, 0, 0, 0, 4'h8);
    step(4'h0, 1, 0, 0, 0, 4'h0);

    // Loading len=15 is clamped to 8. The bit in the load cycle is dropped, so the 8th later 1 matches.
    ld_cfg(8'hFF, 4'd15, 1'b0);
    for (int i = 0; i < 7; i++) step(4'hF, 1, 0, 0, 0, 4'h0);
    step(4'hF, 1, 0, 0, 0, 4'hF);
    step(4'hF, 1, 0, 0, 0, 4'h0);

    // The same stream on all channels matches on every channel in the same cycle.
    ld_cfg(8'b110, 4'd3, 1'b1);
    clr();
    step(4'h0, 1, 0, 0, 0, 4'h0);
    step(4'hF, 1, 0, 0, 0, 4'h0);
    step(4'hF, 1, 0, 0, 0, 4'hF);
    chk("all_ch_count", count, 32'h01010101);
    chk("all_ch_count_cntw2", 32'(count2), 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
